// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter sharing one APB slave between two req/ack masters.
// Ports: pclk/preset, m0_*/m1_* request side, p* APB side, busy/gnt status.
module apb_rr_arbiter #(
  parameter int ADDR_WIDTH = 3,
  parameter int TIMEOUT    = 16
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [31:0]           m0_wdata,
  input  logic [3:0]            m0_strb,
  output logic                  m0_ack,
  output logic                  m0_err,
  output logic [31:0]           m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [31:0]           m1_wdata,
  input  logic [3:0]            m1_strb,
  output logic                  m1_ack,
  output logic                  m1_err,
  output logic [31:0]           m1_rdata,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [31:0]           pwdata,
  output logic [3:0]            pstrb,
  input  logic [31:0]           prdata,
  input  logic                  pready,
  input  logic                  pslverr,
  output logic                  busy,
  output logic                  gnt
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t state;
  logic   last;
  logic [7:0] cnt;

  logic el0;
  logic el1;
  logic any_el;
  logic pick;
  logic [ADDR_WIDTH-1:0] g_addr;
  logic g_we;
  logic [31:0] g_wdata;
  logic [3:0]  g_strb;
  logic tmo_hit;
  logic done;
  logic d_err;
  logic [31:0] d_rdata;

  // A requester being acked this cycle still shows its stale req.
  assign el0    = m0_req & ~m0_ack;
  assign el1    = m1_req & ~m1_ack;
  assign any_el = el0 | el1;

  // On contention the requester not served last wins.
  assign pick = (el0 & el1) ? ~last : el1;

  assign g_addr  = pick ? m1_addr  : m0_addr;
  assign g_we    = pick ? m1_we    : m0_we;
  assign g_wdata = pick ? m1_wdata : m0_wdata;
  assign g_strb  = pick ? m1_strb  : m0_strb;

  assign tmo_hit = (cnt == TMO_LAST);
  assign done    = pready | tmo_hit;
  // A real response beats a coincident timeout.
  assign d_err   = pready ? pslverr : 1'b1;
  assign d_rdata = (pready & ~pwrite) ? prdata : '0;

  always_ff @(posedge pclk) begin
    if (preset) begin
      state    <= IDLE;
      last     <= 1'b1;
      cnt      <= '0;
      psel     <= 1'b0;
      penable  <= 1'b0;
      pwrite   <= 1'b0;
      paddr    <= '0;
      pwdata   <= '0;
      pstrb    <= '0;
      busy     <= 1'b0;
      gnt      <= 1'b0;
      m0_ack   <= 1'b0;
      m0_err   <= 1'b0;
      m0_rdata <= '0;
      m1_ack   <= 1'b0;
      m1_err   <= 1'b0;
      m1_rdata <= '0;
    end else begin
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any_el) begin
            state   <= SETUP;
            psel    <= 1'b1;
            penable <= 1'b0;
            busy    <= 1'b1;
            gnt     <= pick;
            paddr   <= g_addr;
            pwrite  <= g_we;
            pwdata  <= g_we ? g_wdata : '0;
            pstrb   <= g_we ? g_strb : '0;
          end
        end
        SETUP: begin
          state   <= ACCESS;
          penable <= 1'b1;
          cnt     <= '0;
        end
        ACCESS: begin
          if (done) begin
            state   <= IDLE;
            psel    <= 1'b0;
            penable <= 1'b0;
            busy    <= 1'b0;
            last    <= gnt;
            if (gnt) begin
              m1_ack   <= 1'b1;
              m1_err   <= d_err;
              m1_rdata <= d_rdata;
            end else begin
              m0_ack   <= 1'b1;
              m0_err   <= d_err;
              m0_rdata <= d_rdata;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Scoreboard bench for apb_rr_arbiter: master drivers, APB slave,
// transaction-level arbitration model and an ack monitor.
module tb_apb_rr_arbiter;

  localparam int AW  = 3;
  localparam int TMO = 16;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [3:0]    strb;
  } req_t;

  typedef struct {
    int          idx;
    logic        err;
    logic [31:0] rdata;
    int          at;
  } exp_t;

  logic pclk = 1'b0;
  logic preset = 1'b1;
  logic          m_req[2];
  logic          m_we[2];
  logic [AW-1:0] m_addr[2];
  logic [31:0]   m_wdata[2];
  logic [3:0]    m_strb[2];
  logic          m_ack[2];
  logic          m_err[2];
  logic [31:0]   m_rdata[2];
  logic [AW-1:0] paddr;
  logic psel, penable, pwrite, pready, pslverr, busy, gnt;
  logic [31:0] pwdata, prdata;
  logic [3:0]  pstrb;

  always #5 pclk = ~pclk;

  apb_rr_arbiter #(.ADDR_WIDTH(AW), .TIMEOUT(TMO)) dut (
    .pclk(pclk), .preset(preset),
    .m0_req(m_req[0]), .m0_we(m_we[0]), .m0_addr(m_addr[0]),
    .m0_wdata(m_wdata[0]), .m0_strb(m_strb[0]),
    .m0_ack(m_ack[0]), .m0_err(m_err[0]), .m0_rdata(m_rdata[0]),
    .m1_req(m_req[1]), .m1_we(m_we[1]), .m1_addr(m_addr[1]),
    .m1_wdata(m_wdata[1]), .m1_strb(m_strb[1]),
    .m1_ack(m_ack[1]), .m1_err(m_err[1]), .m1_rdata(m_rdata[1]),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata),
    .pready(pready), .pslverr(pslverr), .busy(busy), .gnt(gnt)
  );

  int total = 0;
  int passes = 0;
  int cyc = 0;

  req_t        cur[2];
  bit          pend[2];
  int          last_sv = 1;
  logic [31:0] bank[2];
  exp_t        sbq[$];
  int          ack_cyc[2];
  int          ack_order[$];
  int          set_cyc;
  logic [31:0] held_rd[2];
  logic        held_err[2];

  bit dir_on = 1'b1;
  int dir_wait = 0;
  bit dir_err = 1'b0;
  bit dir_tmo = 1'b0;

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic issue(int i, logic we, logic [AW-1:0] a,
                       logic [31:0] d, logic [3:0] s);
    cur[i] = '{we, a, d, s};
    m_we[i] = we;
    m_addr[i] = a;
    m_wdata[i] = d;
    m_strb[i] = s;
    m_req[i] = 1'b1;
    pend[i] = 1'b1;
  endtask

  // Wait for the ack, keep the stale req through the ack cycle, then drop.
  task automatic finish(int i);
    int n = 0;
    while (pend[i] && n < 200) begin
      @(negedge pclk);
      n++;
    end
    chk("ack_timeout", pend[i], 0);
    pend[i] = 1'b0;
    @(negedge pclk);
    m_req[i] = 1'b0;
  endtask

  task automatic rand_master(int i, int n, bit gaps);
    for (int k = 0; k < n; k++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge pclk);
      issue(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
            $urandom, 4'($urandom_range(0, 15)));
      finish(i);
    end
  endtask

  // APB slave plus grant/phase model.
  initial begin : slave
    int acc;
    int wt;
    bit er;
    bit tm;
    int ei;
    logic [31:0] rd;
    req_t c;
    acc = 0; wt = 0; er = 0; tm = 0; ei = 0;
    pready = 1'b0;
    pslverr = 1'b0;
    prdata = '0;
    forever begin
      @(posedge pclk);
      #1;
      pready = 1'b0;
      pslverr = 1'b0;
      if (preset) begin
        acc = 0;
        continue;
      end
      if (psel && !penable) begin
        chk("grant_has_req", pend[0] | pend[1], 1);
        if (pend[0] && pend[1]) ei = 1 - last_sv;
        else ei = pend[0] ? 0 : 1;
        c = cur[ei];
        set_cyc = cyc;
        chk("setup_gnt", gnt, ei);
        chk("setup_busy", busy, 1);
        chk("setup_apb", {paddr, pwrite, pwdata, pstrb},
            {c.addr, c.we, c.we ? c.wdata : 32'h0,
             c.we ? c.strb : 4'h0});
        acc = 0;
        if (dir_on) begin
          wt = dir_wait; er = dir_err; tm = dir_tmo;
        end else begin
          tm = ($urandom_range(0, 11) == 0);
          wt = $urandom_range(0, 3);
          er = ($urandom_range(0, 3) == 0);
        end
      end else if (psel && penable) begin
        acc++;
        c = cur[ei];
        chk("access_stable",
            {paddr, pwrite, pwdata, pstrb, gnt, busy},
            {c.addr, c.we, c.we ? c.wdata : 32'h0,
             c.we ? c.strb : 4'h0, 1'(ei), 1'b1});
        if (!tm && acc == wt + 1) begin
          rd = c.we ? 32'h0 : bank[c.addr[2]];
          prdata = c.we ? $urandom : bank[c.addr[2]];
          pready = 1'b1;
          pslverr = er;
          if (c.we && !er)
            for (int b = 0; b < 4; b++)
              if (c.strb[b]) bank[c.addr[2]][b*8 +: 8] = c.wdata[b*8 +: 8];
          sbq.push_back('{ei, er, rd, cyc + 1});
          last_sv = ei;
        end else if (tm && acc == TMO) begin
          sbq.push_back('{ei, 1'b1, 32'h0, cyc + 1});
          last_sv = ei;
        end
      end
    end
  end

  // Ack monitor: pops the scoreboard whenever a requester is acked.
  initial begin : monitor
    exp_t e;
    held_rd[0] = '0; held_rd[1] = '0;
    held_err[0] = 1'b0; held_err[1] = 1'b0;
    forever begin
      @(posedge pclk);
      #1;
      if (preset) begin
        chk("reset_apb",
            {paddr, psel, penable, pwrite, pwdata, pstrb, busy, gnt}, 0);
        chk("reset_masters",
            {m_ack[0], m_ack[1], m_err[0], m_err[1],
             m_rdata[0], m_rdata[1]}, 0);
        held_rd[0] = '0; held_rd[1] = '0;
        held_err[0] = 1'b0; held_err[1] = 1'b0;
        sbq.delete();
        last_sv = 1;
        continue;
      end
      chk("dual_ack", m_ack[0] & m_ack[1], 0);
      if (sbq.size() > 0 && sbq[0].at < cyc) begin
        chk("ack_missing", cyc, sbq[0].at);
        pend[sbq[0].idx] = 1'b0;
        void'(sbq.pop_front());
      end
      for (int i = 0; i < 2; i++) begin
        if (m_ack[i]) begin
          if (sbq.size() == 0) begin
            chk("ack_unexpected", 1, 0);
          end else begin
            e = sbq.pop_front();
            chk("ack_who", i, e.idx);
            chk("ack_cycle", cyc, e.at);
            chk("ack_err", m_err[i], e.err);
            chk("ack_rdata", m_rdata[i], e.rdata);
            held_rd[i] = e.rdata;
            held_err[i] = e.err;
          end
          pend[i] = 1'b0;
          ack_cyc[i] = cyc;
          ack_order.push_back(i);
        end else begin
          chk("resp_hold", {m_err[i], m_rdata[i]},
              {held_err[i], held_rd[i]});
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int c0;
    for (int i = 0; i < 2; i++) begin
      m_req[i] = 1'b0; m_we[i] = 1'b0; m_addr[i] = '0;
      m_wdata[i] = '0; m_strb[i] = '0; pend[i] = 1'b0;
      ack_cyc[i] = 0; bank[i] = '0;
    end
    set_cyc = 0;
    repeat (3) @(negedge pclk);
    preset = 1'b0;
    @(negedge pclk);

    // Simultaneous writes after reset: m0 first, m1 three cycles later.
    issue(0, 1'b1, 3'h0, 32'h1111_1111, 4'hF);
    issue(1, 1'b1, 3'h4, 32'h2222_2222, 4'hF);
    c0 = cyc;
    fork
      finish(0);
      finish(1);
    join
    chk("both_m0_lat", ack_cyc[0] - c0, 3);
    chk("both_m1_lat", ack_cyc[1] - c0, 6);

    issue(0, 1'b0, 3'h0, 32'h0, 4'hF);
    issue(1, 1'b0, 3'h4, 32'h0, 4'hF);
    fork
      finish(0);
      finish(1);
    join
    chk("readback_m0", m_rdata[0], 32'h1111_1111);
    chk("readback_m1", m_rdata[1], 32'h2222_2222);

    // Single zero-wait read.
    bank[1] = 32'hDEAD_BEEF;
    issue(0, 1'b0, 3'h4, 32'h0, 4'hF);
    c0 = cyc;
    finish(0);
    chk("read_setup_lat", set_cyc - c0, 1);
    chk("read_ack_lat", ack_cyc[0] - c0, 3);
    chk("read_data", m_rdata[0], 32'hDEAD_BEEF);
    chk("read_err", m_err[0], 0);

    // Continuous requests from both: strict alternation.
    ack_order.delete();
    fork
      rand_master(0, 4, 1'b0);
      rand_master(1, 4, 1'b0);
    join
    chk("alt_count", ack_order.size(), 8);
    for (int k = 1; k < ack_order.size(); k++)
      chk("alt_order", ack_order[k] == ack_order[k-1], 0);

    // Three wait states then a slave error.
    dir_wait = 3;
    dir_err = 1'b1;
    issue(1, 1'b1, 3'h0, 32'hCAFE_F00D, 4'h3);
    c0 = cyc;
    finish(1);
    chk("wait_ack_lat", ack_cyc[1] - c0, 6);
    chk("wait_err", m_err[1], 1);
    dir_wait = 0;
    dir_err = 1'b0;

    // Slave never ready: abort after TMO access cycles.
    dir_tmo = 1'b1;
    issue(0, 1'b0, 3'h0, 32'h0, 4'h0);
    c0 = cyc;
    finish(0);
    chk("tmo_ack_lat", ack_cyc[0] - c0, 2 + TMO);
    chk("tmo_err", m_err[0], 1);
    chk("tmo_rdata", m_rdata[0], 0);
    dir_tmo = 1'b0;
    issue(0, 1'b0, 3'h4, 32'h0, 4'h0);
    c0 = cyc;
    finish(0);
    chk("post_tmo_lat", ack_cyc[0] - c0, 3);

    // Reset while m1 is in ACCESS with m0 waiting.
    dir_tmo = 1'b1;
    issue(1, 1'b0, 3'h0, 32'h0, 4'h0);
    @(negedge pclk);
    issue(0, 1'b1, 3'h4, 32'h5A5A_5A5A, 4'hF);
    repeat (3) @(negedge pclk);
    chk("pre_reset_gnt", {psel, penable, gnt}, 3'b111);
    preset = 1'b1;
    dir_tmo = 1'b0;
    @(negedge pclk);
    preset = 1'b0;
    fork
      finish(0);
      finish(1);
    join
    chk("post_reset_order", ack_cyc[0] < ack_cyc[1], 1);

    // Randomized traffic.
    dir_on = 1'b0;
    fork
      rand_master(0, 25, 1'b1);
      rand_master(1, 25, 1'b1);
    join
    repeat (5) @(negedge pclk);
    chk("scoreboard_empty", sbq.size(), 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
